// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK bit scheduler: state encoding and the
// default timing constants for a 8-bit frame on the standard tone pair.
package fsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_t;

    localparam int DEF_DBIT      = 8;
    localparam int DEF_MARK_DIV  = 163;
    localparam int DEF_SPACE_DIV = 81;
    localparam int DEF_BIT_CLKS  = 5216;

endpackage

// File: rtl/tone_div_counter.sv
// Programmable-modulus counter used as the tone half-period divider.
// The div input carries the terminal count (modulus minus one), so a
// modulus of 2^N is still representable in N bits.
module tone_div_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] div,
    output logic         wrap_tick
);

    logic [N-1:0] r_cnt;

    // Wrap is reported even when clr is also asserted, so the owner can
    // toggle its output on a coincident bit boundary.
    assign wrap_tick = en && (r_cnt >= div);

    // Count while enabled; clear or wrap both return the count to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || wrap_tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + N'(1);
        end
    end

endmodule

// File: rtl/fsk_bit_scheduler.sv
// FSK frame transmitter: latches a DBIT-wide payload on start and emits it
// LSB first as a phase-continuous square wave, one tone per bit value.
module fsk_bit_scheduler
    import fsk_pkg::*;
#(
    parameter int DBIT      = DEF_DBIT,
    parameter int MARK_DIV  = DEF_MARK_DIV,
    parameter int SPACE_DIV = DEF_SPACE_DIV,
    parameter int BIT_CLKS  = DEF_BIT_CLKS,
    parameter int N         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DBIT-1:0] data_in,
    output logic            busy,
    output logic            tone_out,
    output logic            bit_tick,
    output logic            done_tick
);

    localparam int BCW  = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int IDXW = (DBIT > 1) ? $clog2(DBIT) : 1;

    fsk_state_t      r_state;
    logic [DBIT-1:0] r_shreg;
    logic [BCW-1:0]  r_bitCnt;
    logic [IDXW-1:0] r_bitIdx;
    logic            r_tone;

    logic            w_bitTick;
    logic            w_doneTick;
    logic            w_divWrap;
    logic            w_divClr;
    logic            w_divEn;
    logic [N-1:0]    w_divTerm;

    // Bit and frame boundaries are decoded straight from the counters.
    assign w_bitTick  = (r_state == SEND) && (r_bitCnt == BCW'(BIT_CLKS - 1));
    assign w_doneTick = w_bitTick && (r_bitIdx == IDXW'(DBIT - 1));

    // The divider restarts at every bit boundary and is parked in IDLE.
    assign w_divEn   = (r_state == SEND);
    assign w_divClr  = (r_state != SEND) || w_bitTick;
    assign w_divTerm = r_shreg[0] ? N'(MARK_DIV - 1) : N'(SPACE_DIV - 1);

    tone_div_counter #(
        .N(N)
    ) u_toneDiv (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_divClr),
        .en       (w_divEn),
        .div      (w_divTerm),
        .wrap_tick(w_divWrap)
    );

    assign busy      = (r_state == SEND);
    assign tone_out  = r_tone;
    assign bit_tick  = w_bitTick;
    assign done_tick = w_doneTick;

    // Frame FSM with bit counter, shift register and tone output flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitCnt <= '0;
            r_bitIdx <= '0;
            r_tone   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tone   <= 1'b0;
                    r_bitCnt <= '0;
                    r_bitIdx <= '0;
                    if (start) begin
                        r_shreg <= data_in;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_divWrap) begin
                        r_tone <= ~r_tone;
                    end
                    if (w_bitTick) begin
                        r_bitCnt <= '0;
                        r_shreg  <= r_shreg >> 1;
                        r_bitIdx <= r_bitIdx + IDXW'(1);
                    end else begin
                        r_bitCnt <= r_bitCnt + BCW'(1);
                    end
                    // Leaving on the last clock drops the tone immediately.
                    if (w_doneTick) begin
                        r_state  <= IDLE;
                        r_bitIdx <= '0;
                        r_tone   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
